// File: rtl/mult_div_if.sv
// Start/op handshake and HI/LO result bundle between the decode-to-execute
// pipeline register (master) and the multiply/divide unit (slave).
interface mult_div_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        mt_en_i;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, mt_en_i,
    input  busy_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, mt_en_i,
    output busy_o, hi_o, lo_o
  );
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit with fixed multi-cycle latency and HI/LO registers.
// Define MULT_DIV_MADD_EN to add the madd/maddu accumulate ops (110/111).
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  state_t      state, state_next;
  logic [7:0]  count;
  logic [7:0]  count_init;
  logic [31:0] hi_q, lo_q;
  logic [31:0] rhi, rlo;
  logic        skip_wr;

  logic        op_legal, accept, mt_hi, mt_lo, done;
  logic [63:0] res_next;
  logic        skip_next;

  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor;
  logic signed [31:0] q_s, r_s;
  logic [31:0] q_u, r_u;
  logic        div_ovf;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = BUSY;
      BUSY: if (count == 8'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    op_legal = ~bus.op_i[2];
`ifdef MULT_DIV_MADD_EN
    op_legal = op_legal | (bus.op_i[2:1] == 2'b11);
`endif
    accept     = (state == IDLE) && bus.start_i && op_legal;
    mt_hi      = (state == IDLE) && bus.mt_en_i && !accept && (bus.op_i == OP_MTHI);
    mt_lo      = (state == IDLE) && bus.mt_en_i && !accept && (bus.op_i == OP_MTLO);
    done       = (state == BUSY) && (count == 8'd0);
    bus.busy_o = (state == BUSY);
  end

  // Result precomputation; the divisor is forced nonzero so a zero divide never evaluates x.
  always_comb begin
    prod_s  = {{32{bus.a_i[31]}}, bus.a_i} * {{32{bus.b_i[31]}}, bus.b_i};
    prod_u  = {32'd0, bus.a_i} * {32'd0, bus.b_i};
    divisor = (bus.b_i == 32'd0) ? 32'd1 : bus.b_i;
    div_ovf = (bus.a_i == 32'h8000_0000) && (bus.b_i == 32'hFFFF_FFFF);
    q_s     = $signed(bus.a_i) / $signed(divisor);
    r_s     = $signed(bus.a_i) % $signed(divisor);
    q_u     = bus.a_i / divisor;
    r_u     = bus.a_i % divisor;

    res_next   = 64'd0;
    skip_next  = 1'b0;
    count_init = (bus.op_i[2:1] == 2'b01) ? 8'(DIV_CYCLES - 1) : 8'(MULT_CYCLES - 1);
    case (bus.op_i)
      OP_MULT:  res_next = prod_s;
      OP_MULTU: res_next = prod_u;
      OP_DIV: begin
        // INT_MIN / -1 overflows the quotient; it wraps to INT_MIN with zero remainder.
        res_next  = div_ovf ? {32'd0, 32'h8000_0000} : {r_s, q_s};
        skip_next = (bus.b_i == 32'd0);
      end
      OP_DIVU: begin
        res_next  = {r_u, q_u};
        skip_next = (bus.b_i == 32'd0);
      end
`ifdef MULT_DIV_MADD_EN
      OP_MADD:  res_next = {hi_q, lo_q} + prod_s;
      OP_MADDU: res_next = {hi_q, lo_q} + prod_u;
`endif
      default:  res_next = 64'd0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 8'd0;
      rhi     <= 32'd0;
      rlo     <= 32'd0;
      skip_wr <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      if (accept) begin
        {rhi, rlo} <= res_next;
        skip_wr    <= skip_next;
        count      <= count_init;
      end else if (state == BUSY && count != 8'd0) begin
        count <= count - 8'd1;
      end

      if (done) begin
        if (!skip_wr) begin
          hi_q <= rhi;
          lo_q <= rlo;
        end
      end else begin
        if (mt_hi) hi_q <= bus.a_i;
        if (mt_lo) lo_q <= bus.a_i;
      end
    end
  end

  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit (default MULT_CYCLES=5, DIV_CYCLES=10),
// plus hand-written sequences for mthi/mtlo, ignored requests, mid-op reset and maddu.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mult_div_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one start pulse and count the edges busy_o stays high (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cyc = 0;
    if (bus.busy_o) begin
      cyc = 1;
      while (cyc < 300) begin
        @(posedge clk); #1;
        if (!bus.busy_o) break;
        cyc++;
      end
    end
  endtask

  task automatic mt_write(input logic [2:0] op, input logic [31:0] a);
    bus.mt_en_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    @(posedge clk); #1;
    bus.mt_en_i = 1'b0;
  endtask

  initial begin
    int cyc;
    int saw_busy;

    vecs[0] = '{"mult_neg",   3'b000, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{"multu",      3'b001, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{"div_neg",    3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{"div_ovf",    3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[4] = '{"divu_zero",  3'b011, 32'd7,         32'd0,         32'h0000_0000, 32'h8000_0000, 10};
    vecs[5] = '{"div_negdiv", 3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[6] = '{"mult_min",   3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[7] = '{"divu_big",   3'b011, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, 10};

    bus.start_i = 1'b0;
    bus.op_i    = 3'b000;
    bus.a_i     = 32'd0;
    bus.b_i     = 32'd0;
    bus.mt_en_i = 1'b0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_busy", 32'(bus.busy_o), 32'd0);
    check("reset_hi", bus.hi_o, 32'd0);
    check("reset_lo", bus.lo_o, 32'd0);

    // Each vector starts in the first non-busy cycle after the previous one: back-to-back.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].exp_cyc));
      check({vecs[i].name, "_hi"}, bus.hi_o, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, bus.lo_o, vecs[i].exp_lo);
    end

    // mthi / mtlo are single-cycle and never raise busy
    saw_busy = 0;
    mt_write(3'b100, 32'h1234_5678);
    if (bus.busy_o) saw_busy = 1;
    mt_write(3'b101, 32'h9ABC_DEF0);
    if (bus.busy_o) saw_busy = 1;
    check("mt_busy", 32'(saw_busy), 32'd0);
    check("mthi", bus.hi_o, 32'h1234_5678);
    check("mtlo", bus.lo_o, 32'h9ABC_DEF0);

    run_op(3'b011, 32'd7, 32'd0, cyc);
    check("divu0_cycles", 32'(cyc), 32'd10);
    check("divu0_hi", bus.hi_o, 32'h1234_5678);
    check("divu0_lo", bus.lo_o, 32'h9ABC_DEF0);

    // start with op mthi is not an arithmetic op and must be ignored
    bus.start_i = 1'b1; bus.op_i = 3'b100; bus.a_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check("start_mthi_busy", 32'(bus.busy_o), 32'd0);
    check("start_mthi_hi", bus.hi_o, 32'h1234_5678);

    // divu 100/7 with a start and an mt_en injected mid-flight
    bus.start_i = 1'b1; bus.op_i = 3'b011; bus.a_i = 32'd100; bus.b_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cyc = bus.busy_o ? 1 : 0;
    while (bus.busy_o && cyc < 300) begin
      if (cyc == 3) begin
        bus.start_i = 1'b1; bus.op_i = 3'b000; bus.a_i = 32'd5; bus.b_i = 32'd6;
      end else if (cyc == 4) begin
        bus.start_i = 1'b0;
        bus.mt_en_i = 1'b1; bus.op_i = 3'b100; bus.a_i = 32'hDEAD_BEEF;
      end else begin
        bus.start_i = 1'b0;
        bus.mt_en_i = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.busy_o) cyc++;
    end
    bus.start_i = 1'b0;
    bus.mt_en_i = 1'b0;
    check("interf_cycles", 32'(cyc), 32'd10);
    check("interf_lo", bus.lo_o, 32'd14);
    check("interf_hi", bus.hi_o, 32'd2);
    @(posedge clk); #1;
    check("interf_idle", 32'(bus.busy_o), 32'd0);

    // Reset in the second busy cycle aborts the mult
    bus.start_i = 1'b1; bus.op_i = 3'b000; bus.a_i = 32'd5; bus.b_i = 32'd6;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_busy", 32'(bus.busy_o), 32'd0);
    check("rst_mid_hi", bus.hi_o, 32'd0);
    check("rst_mid_lo", bus.lo_o, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("rst_late_busy", 32'(bus.busy_o), 32'd0);
    check("rst_late_hi", bus.hi_o, 32'd0);
    check("rst_late_lo", bus.lo_o, 32'd0);

    // maddu accumulates onto {HI,LO}; illegal when the feature is not built
    mt_write(3'b100, 32'd0);
    mt_write(3'b101, 32'hFFFF_FFFF);
    run_op(3'b111, 32'd1, 32'd1, cyc);
`ifdef MULT_DIV_MADD_EN
    check("maddu_cycles", 32'(cyc), 32'd5);
    check("maddu_hi", bus.hi_o, 32'd1);
    check("maddu_lo", bus.lo_o, 32'd0);
`else
    check("maddu_cycles", 32'(cyc), 32'd0);
    check("maddu_hi", bus.hi_o, 32'd0);
    check("maddu_lo", bus.lo_o, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
